pmem_arbiter: RTL

PMEM_ARBITER -- requirements
Module: pmem_arbiter

---
 rtl/pmem_arbiter_pkg.sv | 20 ++
 rtl/pmem_arbiter_rr_select.sv | 27 ++
 rtl/pmem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory line arbiter. PMEM_ARBITER_PREFETCH_EN
// adds the prefetch states to the enum.
package pmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEMAND   = 2'd1
`ifdef PMEM_ARBITER_PREFETCH_EN
      ,
      ST_PREFETCH = 2'd2,
      ST_PF_HIT   = 2'd3
`endif
   } state_e;

   // Byte stride between consecutive cache lines.
   function automatic int unsigned line_bytes(input int unsigned line_width);
      return line_width / 8;
   endfunction

endpackage

// File: rtl/pmem_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_select #(
   parameter int N     = 2,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             valid
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = PTR_W'((int'(ptr) + i) % N);
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter of NUM_PORTS line requesters onto one memory port.
// Define PMEM_ARBITER_PREFETCH_EN to add a one-line next-line prefetch buffer for port 0.
module pmem_arbiter
   import pmem_arbiter_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WIDTH = 256
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_PORTS-1:0]                   port_read,
   input  logic [NUM_PORTS-1:0]                   port_write,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   port_addr,
   input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0]   port_wdata,
   output logic [LINE_WIDTH-1:0]                  port_rdata,
   output logic [NUM_PORTS-1:0]                   port_resp,
   output logic                                   mem_read,
   output logic                                   mem_write,
   output logic [ADDR_WIDTH-1:0]                  mem_addr,
   output logic [LINE_WIDTH-1:0]                  mem_wdata,
   input  logic [LINE_WIDTH-1:0]                  mem_rdata,
   input  logic                                   mem_resp
);

   localparam int PTR_W = $clog2(NUM_PORTS);
   localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(line_bytes(LINE_WIDTH));

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]       gnt_q, gnt_d;
   logic                   wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;

   logic [NUM_PORTS-1:0]   req_vec;
   logic [NUM_PORTS-1:0]   sel_grant;
   logic                   sel_valid;
   logic [PTR_W-1:0]       sel_idx;
   logic                   pf_hit;

   assign req_vec = port_read | port_write;

   rr_select #(.N(NUM_PORTS), .PTR_W(PTR_W)) u_rr (
      .req   (req_vec),
      .ptr   (rr_ptr_q),
      .grant (sel_grant),
      .valid (sel_valid)
   );

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (sel_grant[i]) sel_idx = PTR_W'(i);
      end
   end

`ifdef PMEM_ARBITER_PREFETCH_EN
   logic                   pf_valid_q, pf_valid_d;
   logic [ADDR_WIDTH-1:0]  pf_tag_q, pf_tag_d;
   logic [LINE_WIDTH-1:0]  pf_data_q, pf_data_d;
   logic                   pf_pend_q, pf_pend_d;
   logic [ADDR_WIDTH-1:0]  pf_next_q, pf_next_d;

   // A pure read by port 0 that wins arbitration and matches the buffer skips memory.
   assign pf_hit = sel_valid && (sel_idx == '0) && port_read[0] && !port_write[0] &&
                   pf_valid_q && (port_addr[0] == pf_tag_q);
`else
   assign pf_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_d      = gnt_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      port_resp  = '0;
      port_rdata = mem_rdata;
`ifdef PMEM_ARBITER_PREFETCH_EN
      pf_valid_d = pf_valid_q;
      pf_tag_d   = pf_tag_q;
      pf_data_d  = pf_data_q;
      pf_pend_d  = pf_pend_q;
      pf_next_d  = pf_next_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (pf_hit) begin
`ifdef PMEM_ARBITER_PREFETCH_EN
               state_d = ST_PF_HIT;
`endif
            end else if (sel_valid) begin
               // Command is captured here so a requester dropping mid-flight cannot disturb it.
               state_d = ST_DEMAND;
               gnt_d   = sel_idx;
               wr_d    = port_write[sel_idx];
               addr_d  = port_addr[sel_idx];
               wdata_d = port_wdata[sel_idx];
            end
`ifdef PMEM_ARBITER_PREFETCH_EN
            else if (pf_pend_q) begin
               state_d   = ST_PREFETCH;
               wr_d      = 1'b0;
               addr_d    = pf_next_q;
               pf_pend_d = 1'b0;
            end
`endif
         end

         ST_DEMAND: begin
            mem_read  = !wr_q;
            mem_write = wr_q;
            if (mem_resp) begin
               port_resp[gnt_q] = 1'b1;
               rr_ptr_d = (gnt_q == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
               state_d  = ST_IDLE;
`ifdef PMEM_ARBITER_PREFETCH_EN
               if (wr_q && (addr_q == pf_tag_q)) pf_valid_d = 1'b0;
               if (!wr_q && (gnt_q == '0)) begin
                  pf_pend_d = 1'b1;
                  pf_next_d = addr_q + LINE_STRIDE;
               end
`endif
            end
         end

`ifdef PMEM_ARBITER_PREFETCH_EN
         ST_PREFETCH: begin
            mem_read = 1'b1;
            if (mem_resp) begin
               pf_valid_d = 1'b1;
               pf_tag_d   = addr_q;
               pf_data_d  = mem_rdata;
               state_d    = ST_IDLE;
            end
         end

         ST_PF_HIT: begin
            port_resp[0] = 1'b1;
            port_rdata   = pf_data_q;
            rr_ptr_d     = PTR_W'(1);
            state_d      = ST_IDLE;
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         gnt_q    <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_q    <= gnt_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

`ifdef PMEM_ARBITER_PREFETCH_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pf_valid_q <= 1'b0;
         pf_tag_q   <= '0;
         pf_data_q  <= '0;
         pf_pend_q  <= 1'b0;
         pf_next_q  <= '0;
      end else begin
         pf_valid_q <= pf_valid_d;
         pf_tag_q   <= pf_tag_d;
         pf_data_q  <= pf_data_d;
         pf_pend_q  <= pf_pend_d;
         pf_next_q  <= pf_next_d;
      end
   end
`endif

endmodule
